cla_accum_ctrl: RTL and testbench

Sequential controller that sits directly downstream of the 100-bit carry-lookahead adder (Adder100) and closes its loop to form a streaming accumulator/subtractor. It drives the adder's a/b/cin ports from a running accumulator and the incoming operand, then registers sum/cout back into that accumulator. Operand packets arrive on a valid/ready stream terminated by in_last. One result per packet is presented on a valid/ready output carrying the final total, a wrap (carry/borrow) count and a beat count.

---
 rtl/cla_accum_ctrl_if.sv | 51 +++++
 rtl/cla_accum_ctrl.sv | 112 +++++++++++
 tb/tb_cla_accum_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cla_accum_ctrl_if.sv
// ============================================================================
// Module      : cla_accum_ctrl_if
// Description : Operand stream, result stream and adder loop signals for
//               cla_accum_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cla_accum_ctrl_if #(
    parameter int WIDTH = 100,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             in_last;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_wraps;
    logic [CNT_W-1:0] out_count;

    // Environment side: operand source, adder and result sink.
    modport master (
        output in_valid, in_data, in_sub, in_last,
        output add_sum, add_cout,
        output out_ready,
        input  in_ready,
        input  add_a, add_b, add_cin,
        input  out_valid, out_sum, out_wraps, out_count
    );

    modport slave (
        input  in_valid, in_data, in_sub, in_last,
        input  add_sum, add_cout,
        input  out_ready,
        output in_ready,
        output add_a, add_b, add_cin,
        output out_valid, out_sum, out_wraps, out_count
    );
endinterface

`default_nettype wire

// File: rtl/cla_accum_ctrl.sv
// ============================================================================
// Module      : cla_accum_ctrl
// Description : Streaming accumulator/subtractor closing the loop around an
//               external combinational carry-lookahead adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_accum_ctrl #(
    parameter int WIDTH = 100,
    parameter int CNT_W = 16
) (
    input  wire               clk,
    input  wire               reset,
    cla_accum_ctrl_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] wraps_q,     wraps_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [WIDTH-1:0] out_sum_q,   out_sum_d;
    logic [CNT_W-1:0] out_wraps_q, out_wraps_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             w_accept;
    logic             w_wrap_evt;
    logic [CNT_W-1:0] w_count_inc;
    logic [CNT_W-1:0] w_wraps_inc;

    // Subtraction is a + ~b + 1, so cin carries the two's-complement increment.
    assign bus.add_a   = acc_q;
    assign bus.add_b   = bus.in_sub ? ~bus.in_data : bus.in_data;
    assign bus.add_cin = bus.in_sub;

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_wraps = out_wraps_q;
    assign bus.out_count = out_count_q;

    assign w_accept    = bus.in_valid && (state_q == ST_ACC);
    // A subtract that produces no carry out has borrowed.
    assign w_wrap_evt  = bus.in_sub ? ~bus.add_cout : bus.add_cout;
    assign w_count_inc = (&count_q) ? count_q : count_q + C_CNT_ONE;
    assign w_wraps_inc = (w_wrap_evt && !(&wraps_q)) ? wraps_q + C_CNT_ONE : wraps_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        wraps_d     = wraps_q;
        count_d     = count_q;
        out_sum_d   = out_sum_q;
        out_wraps_d = out_wraps_q;
        out_count_d = out_count_q;

        case (state_q)
            ST_ACC: begin
                if (w_accept) begin
                    acc_d   = bus.add_sum;
                    count_d = w_count_inc;
                    wraps_d = w_wraps_inc;
                    if (bus.in_last) begin
                        out_sum_d   = bus.add_sum;
                        out_wraps_d = w_wraps_inc;
                        out_count_d = w_count_inc;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    wraps_d = '0;
                    count_d = '0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            wraps_q     <= '0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_wraps_q <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            wraps_q     <= wraps_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_wraps_q <= out_wraps_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cla_accum_ctrl.sv
// ============================================================================
// Module      : tb_cla_accum_ctrl
// Description : Directed table-driven bench for cla_accum_ctrl with a
//               behavioural 100-bit adder closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_accum_ctrl;

    localparam int WIDTH = 100;
    localparam int CNT_W = 16;

    localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ONES_M1 = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sub;
        logic             last;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_sum;
        logic [CNT_W-1:0] exp_wraps;
        logic [CNT_W-1:0] exp_count;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cla_accum_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic [WIDTH:0] w_full;
    assign w_full       = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_cin};
    assign bus.add_sum  = w_full[WIDTH-1:0];
    assign bus.add_cout = w_full[WIDTH];

    cla_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [WIDTH-1:0] s,
                              input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] c);
        chk({tag, ".out_valid"}, WIDTH'(bus.out_valid), WIDTH'(1));
        chk({tag, ".in_ready"},  WIDTH'(bus.in_ready),  WIDTH'(0));
        chk({tag, ".out_sum"},   bus.out_sum, s);
        chk({tag, ".out_wraps"}, WIDTH'(bus.out_wraps), WIDTH'(w));
        chk({tag, ".out_count"}, WIDTH'(bus.out_count), WIDTH'(c));
    endtask

    vec_t vecs [11];

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sub    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        //            data        sub   last  exp_a    exp_sum    wraps count
        vecs[0]  = '{WIDTH'(5),  1'b0, 1'b0, WIDTH'(0),  WIDTH'(0),  16'd0, 16'd0};
        vecs[1]  = '{WIDTH'(7),  1'b0, 1'b1, WIDTH'(5),  WIDTH'(12), 16'd0, 16'd2};
        vecs[2]  = '{C_ONES,     1'b0, 1'b0, WIDTH'(0),  WIDTH'(0),  16'd0, 16'd0};
        vecs[3]  = '{WIDTH'(2),  1'b0, 1'b1, C_ONES,     WIDTH'(1),  16'd1, 16'd2};
        vecs[4]  = '{WIDTH'(3),  1'b0, 1'b0, WIDTH'(0),  WIDTH'(0),  16'd0, 16'd0};
        vecs[5]  = '{WIDTH'(5),  1'b1, 1'b1, WIDTH'(3),  C_ONES_M1,  16'd1, 16'd2};
        vecs[6]  = '{WIDTH'(1),  1'b1, 1'b1, WIDTH'(0),  C_ONES,     16'd1, 16'd1};
        vecs[7]  = '{WIDTH'(0),  1'b1, 1'b1, WIDTH'(0),  WIDTH'(0),  16'd0, 16'd1};
        vecs[8]  = '{WIDTH'(10), 1'b0, 1'b0, WIDTH'(0),  WIDTH'(0),  16'd0, 16'd0};
        vecs[9]  = '{WIDTH'(4),  1'b1, 1'b0, WIDTH'(10), WIDTH'(0),  16'd0, 16'd0};
        vecs[10] = '{WIDTH'(1),  1'b0, 1'b1, WIDTH'(6),  WIDTH'(7),  16'd0, 16'd3};

        // Reset for two cycles
        step();
        step();
        chk("rst.in_ready",  WIDTH'(bus.in_ready),  WIDTH'(1));
        chk("rst.out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
        chk("rst.add_a",     bus.add_a, WIDTH'(0));
        chk("rst.add_cin",   WIDTH'(bus.add_cin), WIDTH'(0));
        chk("rst.out_sum",   bus.out_sum, WIDTH'(0));
        chk("rst.out_count", WIDTH'(bus.out_count), WIDTH'(0));
        reset = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vecs[i].data;
            bus.in_sub   = vecs[i].sub;
            bus.in_last  = vecs[i].last;
            #1;
            chk($sformatf("v%0d.add_a", i),    bus.add_a, vecs[i].exp_a);
            chk($sformatf("v%0d.add_cin", i),  WIDTH'(bus.add_cin), WIDTH'(vecs[i].sub));
            chk($sformatf("v%0d.in_ready", i), WIDTH'(bus.in_ready), WIDTH'(1));
            step();
            if (vecs[i].last) begin
                chk_result($sformatf("v%0d", i), vecs[i].exp_sum, vecs[i].exp_wraps, vecs[i].exp_count);
                // Junk beats during DONE must be ignored while the result is held.
                bus.in_valid = 1'b1;
                bus.in_data  = WIDTH'(99);
                bus.in_sub   = 1'b0;
                bus.in_last  = 1'b1;
                for (int k = 0; k < ((i == 1) ? 5 : 2); k++) begin
                    step();
                    chk_result($sformatf("v%0d.hold%0d", i, k), vecs[i].exp_sum,
                               vecs[i].exp_wraps, vecs[i].exp_count);
                end
                bus.in_valid  = 1'b0;
                bus.in_last   = 1'b0;
                bus.out_ready = 1'b1;
                step();
                bus.out_ready = 1'b0;
                #1;
                chk($sformatf("v%0d.post.in_ready", i),  WIDTH'(bus.in_ready), WIDTH'(1));
                chk($sformatf("v%0d.post.out_valid", i), WIDTH'(bus.out_valid), WIDTH'(0));
                chk($sformatf("v%0d.post.add_a", i),     bus.add_a, WIDTH'(0));
                chk($sformatf("v%0d.post.out_sum", i),   bus.out_sum, vecs[i].exp_sum);
            end
        end

        // Reset mid-packet discards the partial sum and clears held results
        bus.in_valid = 1'b1;
        bus.in_sub   = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = WIDTH'(9);
        step();
        bus.in_data  = WIDTH'(4);
        step();
        chk("mid.add_a", bus.add_a, WIDTH'(13));
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        step();
        reset        = 1'b0;
        chk("mid.rst.add_a",    bus.add_a, WIDTH'(0));
        chk("mid.rst.in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
        chk("mid.rst.out_sum",  bus.out_sum, WIDTH'(0));
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'(6);
        bus.in_last  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk_result("mid.single", WIDTH'(6), 16'd0, 16'd1);

        // Idle cycles in ACC with no valid must not change anything
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
        step();
        chk("idle.add_a",    bus.add_a, WIDTH'(0));
        chk("idle.in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
        chk("idle.out_sum",  bus.out_sum, WIDTH'(6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
